// File: rtl/tpu_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_host_pkg
// Description : Shared types and constants for the systolic-unit host driver.
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_host_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam int NUM_LOAD_BYTES = 8;
    localparam int NUM_OUT_BYTES  = 8;

    // Position of each result byte in the accelerator's output stream.
    localparam logic [2:0] IDX_C00_HI = 3'd0;
    localparam logic [2:0] IDX_C00_LO = 3'd1;
    localparam logic [2:0] IDX_C01_HI = 3'd2;
    localparam logic [2:0] IDX_C01_LO = 3'd3;
    localparam logic [2:0] IDX_C10_HI = 3'd4;
    localparam logic [2:0] IDX_C10_LO = 3'd5;
    localparam logic [2:0] IDX_C11_HI = 3'd6;
    localparam logic [2:0] IDX_C11_LO = 3'd7;

    // Operand image is {x3,x2,x1,x0,w3,w2,w1,w0}; byte idx is streamed idx-th.
    function automatic logic [7:0] operand_byte(input logic [63:0] ops, input logic [2:0] idx);
        return ops[{idx, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/host_result_assembler.sv
`default_nettype none
// ============================================================================
// Module      : host_result_assembler
// Description : Collects the 8-byte result stream and watches for stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module host_result_assembler
    import tpu_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        capture_en,
    input  logic        acc_done,
    input  logic [7:0]  acc_outdata,
    output logic        full,
    output logic        timeout,
    output logic [15:0] c00,
    output logic [15:0] c01,
    output logic [15:0] c10,
    output logic [15:0] c11
);

    localparam int              c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [7:0]         r_bytes [NUM_OUT_BYTES];
    logic [2:0]         r_idx;
    logic [c_cnt_w-1:0] r_gap_cnt;
    logic               w_capture;
    logic               w_gap;

    assign w_capture = capture_en & acc_done;
    assign w_gap     = capture_en & ~acc_done;

    // Both are single-cycle events; the capture of a byte always beats a timeout.
    assign full    = w_capture && (r_idx == 3'(NUM_OUT_BYTES - 1));
    assign timeout = w_gap && (r_gap_cnt == c_cnt_last);

    // Clearing on start leaves every uncaptured byte at zero after a timeout.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            for (int i = 0; i < NUM_OUT_BYTES; i++) begin
                r_bytes[i] <= 8'h00;
            end
            r_idx     <= 3'd0;
            r_gap_cnt <= '0;
        end else if (w_capture) begin
            r_bytes[r_idx] <= acc_outdata;
            r_idx          <= r_idx + 3'd1;
            r_gap_cnt      <= '0;
        end else if (w_gap) begin
            r_gap_cnt <= r_gap_cnt + c_cnt_w'(1);
        end
    end

    assign c00 = {r_bytes[IDX_C00_HI], r_bytes[IDX_C00_LO]};
    assign c01 = {r_bytes[IDX_C01_HI], r_bytes[IDX_C01_LO]};
    assign c10 = {r_bytes[IDX_C10_HI], r_bytes[IDX_C10_LO]};
    assign c11 = {r_bytes[IDX_C11_HI], r_bytes[IDX_C11_LO]};

endmodule
`default_nettype wire

// File: rtl/host_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : host_stream_ctrl
// Description : Streams one 2x2 job into the systolic unit and returns results.
// Revision    : 1.0 - initial release
// ============================================================================
module host_stream_ctrl
    import tpu_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_w,
    input  logic [31:0] job_x,
    input  logic        job_transpose,
    output logic        load_en,
    output logic [7:0]  load_data,
    output logic        transpose,
    input  logic        acc_done,
    input  logic [7:0]  acc_outdata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_c00,
    output logic [15:0] res_c01,
    output logic [15:0] res_c10,
    output logic [15:0] res_c11,
    output logic        res_err,
    output logic        busy
);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_load_idx;
    logic [63:0] r_operands;
    logic        r_load_en;
    logic [7:0]  r_load_data;
    logic        r_transpose;
    logic        r_res_err;
    logic        w_job_fire;
    logic        w_res_fire;
    logic        w_capture_en;
    logic        w_asm_full;
    logic        w_asm_timeout;
    logic        w_load_last;

    assign w_capture_en = (r_state == ST_CAPTURE);
    assign w_load_last  = (r_load_idx == 3'(NUM_LOAD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        job_ready    = 1'b0;
        res_valid    = 1'b0;
        busy         = 1'b1;
        w_job_fire   = 1'b0;
        w_res_fire   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (job_valid) begin
                    w_job_fire   = 1'b1;
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_load_last) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_asm_full || w_asm_timeout) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_res_fire   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Byte 0 comes straight from the job port so the first strobe lands at T+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_en   <= 1'b0;
            r_load_data <= 8'h00;
            r_load_idx  <= 3'd0;
            r_operands  <= 64'h0;
            r_transpose <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            if (w_job_fire) begin
                r_operands  <= {job_x, job_w};
                r_load_en   <= 1'b1;
                r_load_data <= job_w[7:0];
                r_load_idx  <= 3'd0;
                r_transpose <= job_transpose;
                r_res_err   <= 1'b0;
            end else if (r_state == ST_LOAD) begin
                if (w_load_last) begin
                    r_load_en   <= 1'b0;
                    r_load_data <= 8'h00;
                    r_load_idx  <= 3'd0;
                end else begin
                    r_load_idx  <= r_load_idx + 3'd1;
                    r_load_data <= operand_byte(r_operands, r_load_idx + 3'd1);
                end
            end
            if (w_asm_timeout) begin
                r_res_err <= 1'b1;
            end
            if (w_res_fire) begin
                r_transpose <= 1'b0;
            end
        end
    end

    host_result_assembler #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_assembler (
        .clk         (clk),
        .rst         (rst),
        .start       (w_job_fire),
        .capture_en  (w_capture_en),
        .acc_done    (acc_done),
        .acc_outdata (acc_outdata),
        .full        (w_asm_full),
        .timeout     (w_asm_timeout),
        .c00         (res_c00),
        .c01         (res_c01),
        .c10         (res_c10),
        .c11         (res_c11)
    );

    assign load_en   = r_load_en;
    assign load_data = r_load_data;
    assign transpose = r_transpose;
    assign res_err   = r_res_err;

endmodule
`default_nettype wire
